// File: rtl/dds_tone_gen.sv
// Stereo DDS tone source: two phase accumulators share a quarter-wave sine LUT and emit one
// L/R sample pair every 2^DIV_W mclk cycles. Define DDS_GAIN_EN to add gain_shift attenuation.
module dds_tone_gen #(
  parameter int unsigned DIV_W   = 9,
  parameter int unsigned PHASE_W = 24,
  parameter int unsigned LUT_AW  = 8
) (
  input  logic               mclk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [PHASE_W-1:0] fword_l,
  input  logic [PHASE_W-1:0] fword_r,
  input  logic               fword_load,
`ifdef DDS_GAIN_EN
  input  logic [3:0]         gain_shift,
`endif
  output logic [15:0]        l_din,
  output logic [15:0]        r_din,
  output logic               l_en,
  output logic               r_en,
  output logic               busy
);

  typedef enum logic [2:0] {StIdle, StAddrL, StDataL, StAddrR, StDataR} state_e;

  // Elaboration-time sine, sampled at bin centres so the quadrant mirror needs no special case.
  function automatic int lut_entry(int idx);
    real x, x2, term, acc;
    x    = 3.141592653589793 * (2.0 * idx + 1.0) / (4.0 * real'(2 ** LUT_AW));
    x2   = x * x;
    term = x;
    acc  = x;
    for (int k = 1; k < 12; k++) begin
      term = -term * x2 / real'((2 * k) * (2 * k + 1));
      acc  = acc + term;
    end
    return $rtoi(acc * 32767.0 + 0.5);
  endfunction

  logic [14:0] lut_rom [2**LUT_AW];

  for (genvar g = 0; g < 2**LUT_AW; g++) begin : g_lut
    assign lut_rom[g] = 15'(lut_entry(g));
  end

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] phase_l_q, phase_l_d, phase_r_q, phase_r_d;
  logic [PHASE_W-1:0] shadow_l_q, shadow_l_d, shadow_r_q, shadow_r_d;
  logic [PHASE_W-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
  logic [14:0]        mag_q;
  logic               neg_q;
  logic [15:0]        l_din_q, l_din_d, r_din_q, r_din_d;
  logic               l_en_q, l_en_d, r_en_q, r_en_d;

  logic               tick;
  logic [LUT_AW+1:0]  ph_top;
  logic [LUT_AW-1:0]  lut_idx;
  logic [LUT_AW-1:0]  lut_addr;
  logic signed [15:0] sample;
  logic signed [15:0] scaled;

  assign tick = enable && (cnt_q == {DIV_W{1'b1}});

  // Only the right channel reads the LUT in StAddrR; every other cycle looks at the left phase.
  always_comb begin
    ph_top   = (state_q == StAddrR) ? phase_r_q[PHASE_W-1 -: LUT_AW+2]
                                    : phase_l_q[PHASE_W-1 -: LUT_AW+2];
    lut_idx  = ph_top[LUT_AW-1:0];
    lut_addr = ph_top[LUT_AW] ? ~lut_idx : lut_idx;
  end

  always_comb begin
    sample = $signed({1'b0, mag_q});
    if (neg_q) begin
      sample = -sample;
    end
`ifdef DDS_GAIN_EN
    scaled = sample >>> gain_shift;
`else
    scaled = sample;
`endif
  end

  always_comb begin
    cnt_d      = enable ? cnt_q + DIV_W'(1) : '0;
    shadow_l_d = fword_load ? fword_l : shadow_l_q;
    shadow_r_d = fword_load ? fword_r : shadow_r_q;
  end

  always_comb begin
    state_d   = state_q;
    phase_l_d = phase_l_q;
    phase_r_d = phase_r_q;
    act_l_d   = act_l_q;
    act_r_d   = act_r_q;
    l_din_d   = l_din_q;
    r_din_d   = r_din_q;
    l_en_d    = 1'b0;
    r_en_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StAddrL;
          act_l_d = shadow_l_q;
          act_r_d = shadow_r_q;
        end
      end
      StAddrL: begin
        state_d   = StDataL;
        phase_l_d = phase_l_q + act_l_q;
      end
      StDataL: begin
        state_d = StAddrR;
        l_din_d = scaled;
        l_en_d  = 1'b1;
      end
      StAddrR: begin
        state_d   = StDataR;
        phase_r_d = phase_r_q + act_r_q;
      end
      StDataR: begin
        state_d = StIdle;
        r_din_d = scaled;
        r_en_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      phase_l_q  <= '0;
      phase_r_q  <= '0;
      shadow_l_q <= '0;
      shadow_r_q <= '0;
      act_l_q    <= '0;
      act_r_q    <= '0;
      mag_q      <= '0;
      neg_q      <= 1'b0;
      l_din_q    <= '0;
      r_din_q    <= '0;
      l_en_q     <= 1'b0;
      r_en_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_l_q  <= phase_l_d;
      phase_r_q  <= phase_r_d;
      shadow_l_q <= shadow_l_d;
      shadow_r_q <= shadow_r_d;
      act_l_q    <= act_l_d;
      act_r_q    <= act_r_d;
      mag_q      <= lut_rom[lut_addr];
      neg_q      <= ph_top[LUT_AW+1];
      l_din_q    <= l_din_d;
      r_din_q    <= r_din_d;
      l_en_q     <= l_en_d;
      r_en_q     <= r_en_d;
    end
  end

  assign l_din = l_din_q;
  assign r_din = r_din_q;
  assign l_en  = l_en_q;
  assign r_en  = r_en_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_dds_tone_gen.sv
// Scoreboard bench for dds_tone_gen: a sine-based reference model queues expected strobes,
// a negedge monitor pops and compares them along with busy and held sample values.
module tb_dds_tone_gen;

  localparam int DW     = 9;
  localparam int PW     = 24;
  localparam int LAW    = 8;
  localparam int PERIOD = 2 ** DW;

  logic          mclk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [PW-1:0] fword_l;
  logic [PW-1:0] fword_r;
  logic          fword_load;
  logic [15:0]   l_din;
  logic [15:0]   r_din;
  logic          l_en;
  logic          r_en;
  logic          busy;
`ifdef DDS_GAIN_EN
  logic [3:0]    gain_shift;
`endif

  dds_tone_gen #(
    .DIV_W  (DW),
    .PHASE_W(PW),
    .LUT_AW (LAW)
  ) dut (
    .mclk      (mclk),
    .rst_n     (rst_n),
    .enable    (enable),
    .fword_l   (fword_l),
    .fword_r   (fword_r),
    .fword_load(fword_load),
`ifdef DDS_GAIN_EN
    .gain_shift(gain_shift),
`endif
    .l_din     (l_din),
    .r_din     (r_din),
    .l_en      (l_en),
    .r_en      (r_en),
    .busy      (busy)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    int due;
    int val;
  } exp_t;

  exp_t          lq[$];
  exp_t          rq[$];
  int            n_vec  = 0;
  int            n_fail = 0;
  int            cyc    = 0;
  int            m_cnt  = 0;
  int            m_busy = 0;
  int            m_exp_l = 0;
  int            m_exp_r = 0;
  logic [PW-1:0] m_shadow_l, m_shadow_r, m_act_l, m_act_r, m_phase_l, m_phase_r;
  bit            m_tick;

  function automatic int ref_sample(logic [PW-1:0] ph);
    int q, i, mag;
    q = int'(ph[PW-1 -: 2]);
    i = int'(ph[PW-3 -: LAW]);
    if (q % 2 == 1) i = 2 ** LAW - 1 - i;
    mag = $rtoi(32767.0 * $sin(3.141592653589793 * (real'(i) + 0.5) / real'(2 ** (LAW + 1)))
                + 0.5);
    return (q >= 2) ? -mag : mag;
  endfunction

  function automatic int apply_gain(int v);
`ifdef DDS_GAIN_EN
    return v >>> gain_shift;
`else
    return v;
`endif
  endfunction

  function automatic void chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endfunction

  // Reference model: sample schedule and values straight from the tone-generator rules.
  always @(posedge mclk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      m_cnt = 0; m_busy = 0; m_exp_l = 0; m_exp_r = 0;
      m_shadow_l = '0; m_shadow_r = '0; m_act_l = '0; m_act_r = '0;
      m_phase_l = '0; m_phase_r = '0;
      lq.delete();
      rq.delete();
    end else begin
      m_tick = enable && (m_cnt == PERIOD - 1);
      m_cnt  = enable ? (m_cnt + 1) % PERIOD : 0;
      if (m_busy > 0) m_busy--;
      if (m_tick) begin
        m_act_l = m_shadow_l;
        m_act_r = m_shadow_r;
        e.due = cyc + 2; e.val = apply_gain(ref_sample(m_phase_l)); lq.push_back(e);
        e.due = cyc + 4; e.val = apply_gain(ref_sample(m_phase_r)); rq.push_back(e);
        m_phase_l = m_phase_l + m_act_l;
        m_phase_r = m_phase_r + m_act_r;
        m_busy = 4;
      end
      if (fword_load) begin
        m_shadow_l = fword_l;
        m_shadow_r = fword_r;
      end
    end
  end

  // Monitor
  always @(negedge mclk) begin
    exp_t e;
    chk("busy", int'(busy), (m_busy > 0) ? 1 : 0);
    if (l_en === 1'b1) begin
      if (lq.size() == 0) chk("l_en_unexpected", 1, 0);
      else begin
        e = lq.pop_front();
        chk("l_en_cycle", cyc, e.due);
        m_exp_l = e.val;
      end
    end else if (lq.size() != 0 && lq[0].due <= cyc) begin
      chk("l_en_missing", 0, 1);
      void'(lq.pop_front());
    end
    if (r_en === 1'b1) begin
      if (rq.size() == 0) chk("r_en_unexpected", 1, 0);
      else begin
        e = rq.pop_front();
        chk("r_en_cycle", cyc, e.due);
        m_exp_r = e.val;
      end
    end else if (rq.size() != 0 && rq[0].due <= cyc) begin
      chk("r_en_missing", 0, 1);
      void'(rq.pop_front());
    end
    chk("l_din", int'($signed(l_din)), m_exp_l);
    chk("r_din", int'($signed(r_din)), m_exp_r);
  end

  task automatic wait_tick_start();
    int n = 0;
    @(negedge mclk);
    while (m_busy != 4 && n < 2 * PERIOD) begin
      @(negedge mclk);
      n++;
    end
    if (m_busy != 4) chk("tick_timeout", 0, 1);
  endtask

  task automatic wait_ticks(int num);
    for (int t = 0; t < num; t++) begin
      wait_tick_start();
      repeat (5) @(negedge mclk);
    end
  endtask

  task automatic pulse_load(logic [PW-1:0] fl, logic [PW-1:0] fr);
    @(negedge mclk);
    fword_l = fl;
    fword_r = fr;
    fword_load = 1'b1;
    @(negedge mclk);
    fword_load = 1'b0;
  endtask

  // Raise fword_load in the cycle the divider ticks.
  task automatic load_on_tick(logic [PW-1:0] fl, logic [PW-1:0] fr);
    int n = 0;
    @(negedge mclk);
    while (m_cnt != PERIOD - 1 && n < 2 * PERIOD) begin
      @(negedge mclk);
      n++;
    end
    if (m_cnt != PERIOD - 1) chk("align_timeout", 0, 1);
    fword_l = fl;
    fword_r = fr;
    fword_load = 1'b1;
    @(negedge mclk);
    fword_load = 1'b0;
  endtask

  initial begin
    logic [PW-1:0] fl, fr;
    rst_n = 1'b0; enable = 1'b0; fword_l = '0; fword_r = '0; fword_load = 1'b0;
`ifdef DDS_GAIN_EN
    gain_shift = 4'd0;
`endif
    repeat (3) @(negedge mclk);
    rst_n = 1'b1;

    pulse_load('0, '0);
    enable = 1'b1;
    wait_ticks(3);

`ifdef DDS_GAIN_EN
    gain_shift = 4'd1;
`endif
    pulse_load(PW'(1) << 22, '0);
    wait_ticks(5);
`ifdef DDS_GAIN_EN
    gain_shift = 4'd0;
`endif

    for (int it = 0; it < 14; it++) begin
      fl = PW'($urandom);
      fr = PW'($urandom);
      case ($urandom_range(0, 3))
        0: load_on_tick(fl, fr);
        1: begin
          repeat ($urandom_range(1, 400)) @(negedge mclk);
          pulse_load(fl, fr);
        end
        2: pulse_load(PW'(1) << (PW - 1), fr);
        default: load_on_tick('0, fr);
      endcase
      wait_ticks($urandom_range(1, 2));
    end

    // Drop enable while a sequence is in flight.
    wait_tick_start();
    @(negedge mclk);
    enable = 1'b0;
    repeat (1200) @(negedge mclk);
    enable = 1'b1;
    wait_ticks(2);

    // Reset during the DATA_L cycle.
    pulse_load(PW'($urandom), PW'($urandom));
    wait_tick_start();
    @(negedge mclk);
    rst_n = 1'b0;
    @(negedge mclk);
    rst_n = 1'b1;
    repeat (20) @(negedge mclk);
    pulse_load(PW'(3) << 20, PW'(5) << 19);
    wait_ticks(3);

    repeat (10) @(negedge mclk);
    chk("left_queue_drained", lq.size(), 0);
    chk("right_queue_drained", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
